dff_bank_arbiter: RTL and testbench
===================================

// Module: dff_bank_arbiter
// PURPOSE
//  Shares one WIDTH-bit storage register, built from D flip-flops, between N_REQ requesters.
//  Arbitration is round-robin. Each granted request performs one operation on the register:
//  LOAD, SET-all, CLEAR-all or TOGGLE. The block sits between control agents and the shared
//  state register. It exposes q/qbar to the rest of the design.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  WIDTH      8   register width in bits
//  RESET_VAL  0   value loaded into q on reset (WIDTH bits)
// PORTS
//  clk    in   1            rising-edge clock, single clock domain
//  reset  in   1            asynchronous, active-low reset
//  req    in   N_REQ        per-requester level request; held until the matching ack
//  op     in   2*N_REQ      op for requester i in op[2i+1:2i]: 00 LOAD, 01 SET, 10 CLR, 11 TOGGLE
//  wdata  in   WIDTH*N_REQ  LOAD data for requester i in wdata[WIDTH*i +: WIDTH]
//  gnt    out  N_REQ        one-hot grant, registered
//  ack    out  N_REQ        one-cycle completion pulse, registered
//  busy   out  1            high while state is WRITE
//  q      out  WIDTH        shared register contents
//  qbar   out  WIDTH        ~q, combinational
// BEHAVIOUR
//  Reset (reset=0, async, overrides everything):
//   q=RESET_VAL, gnt=0, ack=0, busy=0, ptr=0, state=IDLE. An in-flight write is discarded.
//  FSM states:
//   IDLE:
//    - eligible = req & ~ack. Requester i is masked in its own ack cycle, which prevents a
//      double write before it drops req.
//    - If eligible != 0: winner = first set bit searching ptr, ptr+1, ... with wrap mod N_REQ.
//    - Next edge: gnt <= onehot(winner), state <= WRITE.
//   WRITE:
//    - Next edge, if req[winner]=1:
//      - q <= f(op[winner], q, wdata[winner]);
//      - ack <= gnt; gnt <= 0;
//      - ptr <= (winner+1) mod N_REQ;
//      - state <= IDLE.
//    - Next edge, if req[winner]=0 (abort): q unchanged, no ack, gnt <= 0, ptr unchanged,
//      state <= IDLE.
//  Op function f:
//   LOAD -> wdata; SET -> {WIDTH{1'b1}}; CLR -> 0; TOGGLE -> ~q.
//   op and wdata are sampled at the WRITE edge, so the requester holds them stable while req=1.
//  Timing:
//   - Latency: req high before edge k (IDLE) -> gnt high after k -> q updated and ack high
//     after k+1.
//   - Throughput: at most one write per 2 cycles.
//   - ack is high for exactly one cycle.
//  Boundary conditions:
//   - Simultaneous requests: only the winner is granted; losers stay pending, no starvation
//     (bounded wait <= N_REQ grants).
//   - ptr wraps N_REQ-1 -> 0.
//   - New req during WRITE: ignored until the next IDLE cycle.
//   - gnt, ack and busy never have more than one bit set. gnt and ack are never high for the
//     same requester in the same cycle.
//   - Reset during WRITE: q returns to RESET_VAL, and no ack is issued.
// STRUCTURE
//  Package dff_bank_pkg:
//   - op localparams OP_LOAD=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_TOG=2'b11;
//   - state encodings ST_IDLE, ST_WRITE.
//  Sub-module dff_bank:
//   - WIDTH-bit register; ports clk, reset (async active-low, loads RESET_VAL), en, d, q, qbar.
//   - The arbiter drives en for one cycle on a successful WRITE.
//  Arbiter, ptr, FSM and op mux live in dff_bank_arbiter.
// TESTING
//  1. Reset: reset=0 while req=4'b1111 -> q=8'h00, gnt=0, ack=0, busy=0 throughout.
//  2. Single LOAD: req=0001, op0=00, wdata0=8'hA5 -> gnt=0001 one cycle later, q=8'hA5 and
//     ack=0001 the following cycle, no second write although req0 drops one cycle late.
//  3. Round-robin: req=1111 held, ops=LOAD with wdata i=8'h10+i -> grant order 0,1,2,3,0;
//     q sequence 10,11,12,13,10.
//  4. Ops on q=8'h3C: SET -> FF; CLR -> 00; TOGGLE twice from 3C -> C3 then 3C; qbar=~q every
//     cycle.
//  5. Abort: req=0010, drop req1 in the WRITE cycle -> q unchanged, no ack, next grant still
//     starts the search from requester 1.
//  6. Reset mid-WRITE: after LOAD 8'h5A grant, pulse reset=0 before the WRITE edge ->
//     q=RESET_VAL, no ack, ptr=0.

Source files
------------

// File: rtl/dff_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bank_pkg
//  Description : Shared op codes and FSM state encoding for dff_bank_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_bank_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dff_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bank
//  Description : WIDTH-bit D flip-flop register with enable and inverted output.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bank_arbiter
//  Description : Round-robin arbiter granting N_REQ agents one LOAD/SET/CLR/
//                TOGGLE operation at a time on a shared D flip-flop register.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int               N_REQ     = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_SUM_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(N_REQ - 1);

    state_t             r_state, w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [c_PTR_W-1:0] r_win, w_win_nxt;
    logic [c_PTR_W-1:0] w_winner;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]   r_ack, w_ack_nxt;
    logic [N_REQ-1:0]   w_elig;
    logic               w_found;
    logic               w_en;
    logic [c_SUM_W-1:0] w_sum;
    logic [1:0]         w_op_arr [N_REQ];
    logic [WIDTH-1:0]   w_wd_arr [N_REQ];
    logic [WIDTH-1:0]   w_d;
    logic [WIDTH-1:0]   w_q;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_op_arr[gi] = op[2*gi +: 2];
            assign w_wd_arr[gi] = wdata[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // A requester is masked during its own ack cycle so a late req drop cannot re-win.
    always_comb begin
        w_elig   = req & ~r_ack;
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = c_SUM_W'(r_ptr) + c_SUM_W'(k);
            if (w_sum >= c_SUM_W'(N_REQ)) begin
                w_sum = w_sum - c_SUM_W'(N_REQ);
            end
            if (!w_found && w_elig[w_sum[c_PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_win_nxt           = w_winner;
                    w_state_nxt         = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
                // A dropped request aborts: no write, no ack, pointer stays put.
                if (req[r_win]) begin
                    w_en      = 1'b1;
                    w_ack_nxt = r_gnt;
                    w_ptr_nxt = (r_win == c_LAST) ? '0 : r_win + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_d = w_q;
        case (w_op_arr[r_win])
            OP_LOAD: w_d = w_wd_arr[r_win];
            OP_SET:  w_d = '1;
            OP_CLR:  w_d = '0;
            OP_TOG:  w_d = ~w_q;
            default: w_d = w_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    dff_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .d     (w_d),
        .q     (w_q),
        .qbar  (qbar)
    );

    assign q    = w_q;
    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign busy = (r_state == ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_bank_arbiter
//  Description : Self-checking bench for dff_bank_arbiter with a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int               N  = 4;
    localparam int               W  = 8;
    localparam logic [W-1:0]     RV = 8'h00;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [2*N-1:0] op    = '0;
    logic [W*N-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   qbar;

    int n_tests = 0;
    int n_fail  = 0;

    int           ack_log[$];
    logic [W-1:0] q_log[$];

    always #5 clk = ~clk;

    dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op    (op),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .q     (q),
        .qbar  (qbar)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: who holds the grant (-1 none), who is being acked (-1 none), pointer, register.
    int           m_win = -1;
    int           m_ack = -1;
    int           m_ptr = 0;
    logic [W-1:0] m_q   = RV;

    function automatic int pick(input logic [N-1:0] r, input int ptr, input int ackw);
        int res = -1;
        for (int k = 0; k < N; k++) begin
            if (res < 0 && r[(ptr + k) % N] && ((ptr + k) % N) != ackw) res = (ptr + k) % N;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] apply(input logic [1:0] o, input logic [W-1:0] cur,
                                           input logic [W-1:0] d);
        case (o)
            2'b00:   return d;
            2'b01:   return '1;
            2'b10:   return '0;
            default: return ~cur;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_win <= -1;
            m_ack <= -1;
            m_ptr <= 0;
            m_q   <= RV;
        end else if (m_win < 0) begin
            m_ack <= -1;
            m_win <= pick(req, m_ptr, m_ack);
        end else begin
            m_win <= -1;
            if (req[m_win]) begin
                m_q   <= apply(op[2*m_win +: 2], m_q, wdata[W*m_win +: W]);
                m_ack <= m_win;
                m_ptr <= (m_win + 1) % N;
            end else begin
                m_ack <= -1;
            end
        end
    end

    logic [W-1:0] e_qbar;
    always @(negedge clk) begin
        e_qbar = ~m_q;
        check("gnt",  32'(gnt),  (m_win >= 0) ? (1 << m_win) : 0);
        check("ack",  32'(ack),  (m_ack >= 0) ? (1 << m_ack) : 0);
        check("busy", 32'(busy), 32'(m_win >= 0));
        check("q",    32'(q),    32'(m_q));
        check("qbar", 32'(qbar), 32'(e_qbar));
        for (int k = 0; k < N; k++) begin
            if (ack[k]) begin
                ack_log.push_back(k);
                q_log.push_back(q);
            end
        end
    end

    task automatic set_lane(input int i, input logic [1:0] o, input logic [W-1:0] d);
        op[2*i +: 2]  = o;
        wdata[W*i +: W] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic do_op(input int i, input logic [1:0] o, input logic [W-1:0] d,
                         output logic [W-1:0] qv);
        logic got = 1'b0;
        set_lane(i, o, d);
        req[i] = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (ack[i]) got = 1'b1;
        end
        qv = q;
        req[i] = 1'b0;
        check("op_ack_seen", 32'(got), 32'd1);
        tick();
    endtask

    int           exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_q[5]   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [W-1:0] qv;

    initial begin
        // 1. reset held with all requests high
        reset = 1'b0;
        req   = 4'b1111;
        repeat (3) tick();
        check("rst_q", 32'(q), 32'h00);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        req   = '0;
        reset = 1'b1;
        tick();

        // 2. single LOAD, request dropped one cycle after ack
        set_lane(0, 2'b00, 8'hA5);
        req = 4'b0001;
        tick();
        check("t2_gnt", 32'(gnt), 32'h1);
        check("t2_busy", 32'(busy), 32'h1);
        tick();
        check("t2_q", 32'(q), 32'hA5);
        check("t2_ack", 32'(ack), 32'h1);
        check("t2_gnt_off", 32'(gnt), 32'h0);
        tick();
        check("t2_no_regrant", 32'(gnt), 32'h0);
        check("t2_ack_once", 32'(ack), 32'h0);
        req = '0;
        tick();
        check("t2_q_hold", 32'(q), 32'hA5);

        // 3. round-robin with all requesters loading
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 2'b00, 8'(8'h10 + i));
        ack_log.delete();
        q_log.delete();
        req = 4'b1111;
        repeat (10) tick();
        req = '0;
        repeat (2) tick();
        check("t3_count", 32'(ack_log.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            check("t3_order", (j < ack_log.size()) ? 32'(ack_log[j]) : 32'hFFFF_FFFF, 32'(exp_ord[j]));
            check("t3_qseq", (j < q_log.size()) ? 32'(q_log[j]) : 32'hFFFF_FFFF, 32'(exp_q[j]));
        end

        // 4. ops on 3C from different requesters
        do_op(0, 2'b00, 8'h3C, qv);
        check("t4_load", 32'(qv), 32'h3C);
        do_op(2, 2'b01, 8'h00, qv);
        check("t4_set", 32'(qv), 32'hFF);
        do_op(0, 2'b00, 8'h3C, qv);
        do_op(3, 2'b10, 8'hFF, qv);
        check("t4_clr", 32'(qv), 32'h00);
        do_op(0, 2'b00, 8'h3C, qv);
        do_op(1, 2'b11, 8'h00, qv);
        check("t4_tog1", 32'(qv), 32'hC3);
        check("t4_qbar", 32'(qbar), 32'h3C);
        do_op(0, 2'b11, 8'h00, qv);
        check("t4_tog2", 32'(qv), 32'h3C);

        // 5. abort by requester 1, pointer must still favour requester 1
        set_lane(1, 2'b00, 8'h77);
        req = 4'b0010;
        tick();
        check("t5_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("t5_no_ack", 32'(ack), 32'h0);
        check("t5_q_same", 32'(q), 32'h3C);
        for (int i = 0; i < N; i++) set_lane(i, 2'b00, 8'(8'h40 + i));
        req = 4'b1111;
        tick();
        check("t5_resume", 32'(gnt), 32'h2);
        req = '0;
        repeat (2) tick();
        check("t5_q_after", 32'(q), 32'h3C);

        // 6. reset pulse between grant and write edge
        set_lane(2, 2'b00, 8'h5A);
        req = 4'b0100;
        tick();
        check("t6_gnt", 32'(gnt), 32'h4);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_q", 32'(q), 32'(RV));
        check("t6_rst_gnt", 32'(gnt), 32'h0);
        req = '0;
        #3 reset = 1'b1;
        tick();
        check("t6_no_ack", 32'(ack), 32'h0);
        check("t6_q", 32'(q), 32'(RV));
        req = 4'b1111;
        tick();
        check("t6_ptr0", 32'(gnt), 32'h1);
        req = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
